data_sync_tx: RTL and testbench

Source-domain launcher for the multi-bit CDC path. It accepts a word from local logic over a valid/ready handshake and drives `unsync_bus` plus a level `bus_en` toward the destination-domain `data_sync` receiver. It runs a 4-phase request/acknowledge protocol: the bus is held stable until the destination echoes the request back, which guarantees capture before the next word is launched. It sits in the transmitting clock domain, one per crossing.

---
 rtl/data_sync_tx_pkg.sv | 18 +
 rtl/data_sync_tx_if.sv | 27 ++
 rtl/data_sync_tx_bit_sync.sv | 26 ++
 rtl/data_sync_tx.sv | 99 +++++++++
 tb/tb_data_sync_tx.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sync_tx_pkg.sv
// Shared CDC definitions for the data_sync_tx launcher and the data_sync receiver.
package data_sync_tx_pkg;

  // Four-phase handshake states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } cdc_state_t;

  // Default depth of the level synchronizers on both sides of the crossing.
  localparam int DEF_NUM_STAGES = 2;

  // Default width of the crossing data word.
  localparam int DEF_BUS_WIDTH  = 8;

endpackage

// File: rtl/data_sync_tx_if.sv
// Source-side handshake plus the request/acknowledge bus of the CDC launcher.
interface data_sync_tx_if
  import data_sync_tx_pkg::*;
#(
  parameter int bus_width = DEF_BUS_WIDTH
);
  logic [bus_width-1:0] src_data;
  logic                 src_valid;
  logic                 src_ready;
  logic                 ack;
  logic [bus_width-1:0] unsync_bus;
  logic                 bus_en;
  logic                 busy;
  logic                 done;

  // The launcher drives the crossing and the source-side ready/status.
  modport master (
    input  src_data, src_valid, ack,
    output src_ready, unsync_bus, bus_en, busy, done
  );

  // Local logic and the destination side of the crossing.
  modport slave (
    output src_data, src_valid, ack,
    input  src_ready, unsync_bus, bus_en, busy, done
  );
endinterface

// File: rtl/data_sync_tx_bit_sync.sv
// Multi-flop level synchronizer for a single control bit crossing into clck.
module bit_sync
  import data_sync_tx_pkg::*;
#(
  parameter int num_stages = DEF_NUM_STAGES
) (
  input  logic clck,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [num_stages-1:0] sync_p;

  // Shift the asynchronous level through the flop chain; reset clears it.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[num_stages-2:0], d};
    end
  end

  assign q = sync_p[num_stages-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source-domain launcher: holds a word on unsync_bus and runs a four-phase
// bus_en/ack handshake so the destination captures it before the next word.
module data_sync_tx
  import data_sync_tx_pkg::*;
#(
  parameter int bus_width  = DEF_BUS_WIDTH,
  parameter int num_stages = DEF_NUM_STAGES
) (
  input  logic               clck,
  input  logic               rst,
  data_sync_tx_if.master     bus
);

  cdc_state_t           state;
  cdc_state_t           state_nxt;
  logic                 ack_s;
  logic                 bus_en_q;
  logic                 bus_en_nxt;
  logic                 done_q;
  logic                 done_nxt;
  logic                 load;
  logic [bus_width-1:0] unsync_q;

  bit_sync #(
    .num_stages (num_stages)
  ) u_ack_sync (
    .clck (clck),
    .rst  (rst),
    .d    (bus.ack),
    .q    (ack_s)
  );

  // Handshake state and the registered request/done levels.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bus_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus_en_q <= bus_en_nxt;
      done_q   <= done_nxt;
    end
  end

  // Data word is captured only on accept and held through the whole handshake.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      unsync_q <= '0;
    end else if (load) begin
      unsync_q <= bus.src_data;
    end
  end

  // Next-state logic; SETUP waits out a stale acknowledge before requesting.
  always_comb begin
    state_nxt  = state;
    bus_en_nxt = bus_en_q;
    done_nxt   = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.src_valid) begin
          load      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (!ack_s) begin
          bus_en_nxt = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          bus_en_nxt = 1'b0;
          state_nxt  = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        bus_en_nxt = 1'b0;
      end
    endcase
  end

  assign bus.src_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.unsync_bus = unsync_q;
  assign bus.bus_en     = bus_en_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// Directed bench for data_sync_tx with a destination-domain echo model.
module tb_data_sync_tx;

  logic clck;
  logic dclk;
  logic rst;
  int   dhalf;

  logic ack_man;
  logic use_dest;
  logic d1, d2, d3;
  logic [7:0] rx_q[$];

  int n_cmp;
  int n_err;
  int done_cnt;
  int viol;
  logic [7:0] last_unsync;

  data_sync_tx_if #(.bus_width(8)) bus_if ();

  data_sync_tx #(
    .bus_width  (8),
    .num_stages (2)
  ) dut (
    .clck (clck),
    .rst  (rst),
    .bus  (bus_if.master)
  );

  assign bus_if.ack = use_dest ? d3 : ack_man;

  initial begin
    clck = 1'b0;
    forever #6 clck = ~clck;
  end

  initial begin
    dclk = 1'b0;
    #1;
    forever #(dhalf) dclk = ~dclk;
  end

  // Destination model: 2-flop sync of bus_en, capture on its rise, echo one flop later.
  always @(posedge dclk or negedge rst) begin
    if (!rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
      d3 <= 1'b0;
    end else begin
      d1 <= bus_if.bus_en;
      d2 <= d1;
      d3 <= d2;
      if (d2 && !d3) rx_q.push_back(bus_if.unsync_bus);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {bus_if.src_ready, bus_if.busy, bus_if.bus_en, bus_if.done, bus_if.unsync_bus};
  endfunction

  task automatic tick();
    @(posedge clck);
    @(negedge clck);
    if (bus_if.done === 1'b1) done_cnt++;
    if (bus_if.bus_en === 1'b1 && bus_if.unsync_bus !== last_unsync) viol++;
    last_unsync = bus_if.unsync_bus;
  endtask

  task automatic run_stream(input int n, input bit rnd);
    logic [7:0] exp_q[$];
    logic [7:0] w;
    logic       rdy_exp;
    int d0, v0, gap, waitc;
    exp_q.delete();
    rx_q.delete();
    d0 = done_cnt;
    v0 = viol;
    for (int i = 0; i < n; i++) begin
      gap = rnd ? int'($urandom_range(0, 3)) : 0;
      if (gap > 0) begin
        bus_if.src_valid = 1'b0;
        repeat (gap) tick();
      end
      w = rnd ? 8'($urandom) : 8'(i + 1);
      bus_if.src_data  = w;
      bus_if.src_valid = 1'b1;
      waitc = 0;
      while (bus_if.src_ready !== 1'b1 && waitc < 2000) begin
        rdy_exp = ~bus_if.busy;
        chk("no_accept_while_busy", 32'(bus_if.src_ready), 32'(rdy_exp));
        tick();
        waitc++;
      end
      if (waitc >= 2000) begin
        chk("stream_ready_timeout", 32'(bus_if.src_ready), 32'd1);
        bus_if.src_valid = 1'b0;
        return;
      end
      tick();
      exp_q.push_back(w);
    end
    bus_if.src_valid = 1'b0;
    waitc = 0;
    while ((bus_if.busy !== 1'b0 || rx_q.size() < n) && waitc < 4000) begin
      tick();
      waitc++;
    end
    chk("stream_drain_busy", 32'(bus_if.busy), 32'd0);
    chk("stream_rx_count", 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      chk("stream_word", 32'(rx_q[i]), 32'(exp_q[i]));
    end
    chk("stream_done_count", 32'(done_cnt - d0), 32'(n));
    chk("stream_bus_stable", 32'(viol - v0), 32'd0);
  endtask

  initial begin
    int d0;
    n_cmp = 0;
    n_err = 0;
    done_cnt = 0;
    viol = 0;
    last_unsync = 8'h00;
    dhalf = 18;
    rst = 1'b0;
    ack_man = 1'b0;
    use_dest = 1'b0;
    bus_if.src_valid = 1'b0;
    bus_if.src_data  = 8'h00;

    // Reset state and idle hold
    @(negedge clck);
    @(negedge clck);
    chk("reset_outs", 32'(outs()), 32'h800);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outs", 32'(outs()), 32'h800);
    end

    // Single word 0xA5 with a clock-aligned acknowledge
    bus_if.src_data  = 8'hA5;
    bus_if.src_valid = 1'b1;
    tick();
    chk("a5_data_after_accept", 32'(bus_if.unsync_bus), 32'hA5);
    chk("a5_bus_en_low_at_k", 32'(bus_if.bus_en), 32'd0);
    chk("a5_busy", 32'(bus_if.busy), 32'd1);
    chk("a5_ready_low", 32'(bus_if.src_ready), 32'd0);
    bus_if.src_valid = 1'b0;
    bus_if.src_data  = 8'h00;
    tick();
    chk("a5_bus_en_high_k1", 32'(bus_if.bus_en), 32'd1);
    chk("a5_data_held", 32'(bus_if.unsync_bus), 32'hA5);
    tick();
    tick();
    chk("a5_req_wait", 32'(bus_if.bus_en), 32'd1);
    ack_man = 1'b1;
    tick();
    chk("a5_ack_edge1", 32'(bus_if.bus_en), 32'd1);
    tick();
    chk("a5_ack_edge2", 32'(bus_if.bus_en), 32'd1);
    tick();
    chk("a5_ack_edge3", 32'(bus_if.bus_en), 32'd0);
    chk("a5_release_busy", 32'(bus_if.busy), 32'd1);
    d0 = done_cnt;
    ack_man = 1'b0;
    tick();
    chk("a5_done_edge1", 32'(bus_if.done), 32'd0);
    tick();
    chk("a5_done_edge2", 32'(bus_if.done), 32'd0);
    tick();
    chk("a5_done_edge3", 32'(bus_if.done), 32'd1);
    chk("a5_idle_busy", 32'(bus_if.busy), 32'd0);
    chk("a5_idle_ready", 32'(bus_if.src_ready), 32'd1);
    tick();
    chk("a5_done_one_cycle", 32'(bus_if.done), 32'd0);
    chk("a5_done_count", 32'(done_cnt - d0), 32'd1);
    chk("a5_data_remains", 32'(bus_if.unsync_bus), 32'hA5);

    // Stale acknowledge held high at accept
    ack_man = 1'b1;
    repeat (3) tick();
    bus_if.src_data  = 8'h77;
    bus_if.src_valid = 1'b1;
    tick();
    bus_if.src_valid = 1'b0;
    chk("stale_busy", 32'(bus_if.busy), 32'd1);
    chk("stale_data", 32'(bus_if.unsync_bus), 32'h77);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stale_hold_bus_en", 32'(bus_if.bus_en), 32'd0);
    end
    ack_man = 1'b0;
    tick();
    chk("stale_low_edge1", 32'(bus_if.bus_en), 32'd0);
    tick();
    chk("stale_low_edge2", 32'(bus_if.bus_en), 32'd0);
    tick();
    chk("stale_bus_en_rise", 32'(bus_if.bus_en), 32'd1);
    ack_man = 1'b1;
    repeat (3) tick();
    chk("stale_bus_en_drop", 32'(bus_if.bus_en), 32'd0);
    ack_man = 1'b0;
    repeat (3) tick();
    chk("stale_done", 32'(bus_if.done), 32'd1);
    tick();

    // Reset pulse while in REQ with 0x3C, then a normal 0x5A
    bus_if.src_data  = 8'h3C;
    bus_if.src_valid = 1'b1;
    tick();
    bus_if.src_valid = 1'b0;
    tick();
    chk("r3c_bus_en_high", 32'(bus_if.bus_en), 32'd1);
    tick();
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    chk("r3c_async_outs", 32'(outs()), 32'h800);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("r3c_no_done", 32'(done_cnt - d0), 32'd0);
    chk("r3c_idle_outs", 32'(outs()), 32'h800);
    bus_if.src_data  = 8'h5A;
    bus_if.src_valid = 1'b1;
    tick();
    bus_if.src_valid = 1'b0;
    chk("w5a_data", 32'(bus_if.unsync_bus), 32'h5A);
    tick();
    chk("w5a_bus_en_high", 32'(bus_if.bus_en), 32'd1);
    ack_man = 1'b1;
    repeat (3) tick();
    chk("w5a_bus_en_drop", 32'(bus_if.bus_en), 32'd0);
    ack_man = 1'b0;
    repeat (2) tick();
    chk("w5a_no_done_yet", 32'(bus_if.done), 32'd0);
    tick();
    chk("w5a_done", 32'(bus_if.done), 32'd1);
    chk("w5a_data_remains", 32'(bus_if.unsync_bus), 32'h5A);
    repeat (20) tick();

    // Back-to-back 0x01..0x03 through the destination model
    use_dest = 1'b1;
    run_stream(3, 1'b0);

    // 200 random words, destination 3x slower, then 3x faster
    dhalf = 18;
    run_stream(200, 1'b1);
    dhalf = 2;
    run_stream(200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
